// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: forwarding selects, PC-source priority,
// and stall/flush generation from shadow copies of the EX/MEM/WB destination fields.
module hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rs_d,
    input  logic [REG_W-1:0] rt_d,
    input  logic [REG_W-1:0] write_reg_d,
    input  logic             reg_write_d,
    input  logic             mem_to_reg_d,
    input  logic             branch_d,
    input  logic             branch_taken_d,
    input  logic             jump_d,
    input  logic             jr_d,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             fwd_a_d,
    output logic             fwd_b_d,
    output logic             pc_sel_jr,
    output logic             pc_sel_j,
    output logic             pc_sel_br,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic [CNT_W-1:0] stall_count
);

    logic [REG_W-1:0] rs_e, rt_e, wr_e, wr_m, wr_w;
    logic             rw_e, m2r_e, rw_m, m2r_m, rw_w;
    logic [CNT_W-1:0] cnt_q;

    logic e_hits_rs, e_hits_rt, m_hits_rs, m_hits_rt;
    logic lw_stall, br_stall, jr_stall, stall;

    // Register 0 is hard-wired, so a zero destination never creates a dependency.
    assign e_hits_rs = (wr_e != '0) && (wr_e == rs_d);
    assign e_hits_rt = (wr_e != '0) && (wr_e == rt_d);
    assign m_hits_rs = (wr_m != '0) && (wr_m == rs_d);
    assign m_hits_rt = (wr_m != '0) && (wr_m == rt_d);

    assign lw_stall = m2r_e && (e_hits_rs || e_hits_rt);
    assign br_stall = branch_d && ((rw_e && (e_hits_rs || e_hits_rt)) ||
                                   (m2r_m && (m_hits_rs || m_hits_rt)));
    assign jr_stall = jr_d && ((rw_e && e_hits_rs) || (m2r_m && m_hits_rs));
    assign stall    = !rst && (lw_stall || br_stall || jr_stall);

    always_comb begin
        fwd_a_e   = 2'd0;
        fwd_b_e   = 2'd0;
        fwd_a_d   = 1'b0;
        fwd_b_d   = 1'b0;
        pc_sel_jr = 1'b0;
        pc_sel_j  = 1'b0;
        pc_sel_br = 1'b0;
        if (!rst) begin
            // MEM holds the younger result, so it takes priority over WB.
            if (rw_m && (wr_m != '0) && (wr_m == rs_e))
                fwd_a_e = 2'd2;
            else if (rw_w && (wr_w != '0) && (wr_w == rs_e))
                fwd_a_e = 2'd1;
            if (rw_m && (wr_m != '0) && (wr_m == rt_e))
                fwd_b_e = 2'd2;
            else if (rw_w && (wr_w != '0) && (wr_w == rt_e))
                fwd_b_e = 2'd1;
            fwd_a_d = rw_m && m_hits_rs;
            fwd_b_d = rw_m && m_hits_rt;
            if (!stall) begin
                if (jr_d)
                    pc_sel_jr = 1'b1;
                else if (jump_d)
                    pc_sel_j = 1'b1;
                else if (branch_d && branch_taken_d)
                    pc_sel_br = 1'b1;
            end
        end
    end

    assign stall_f     = stall;
    assign stall_d     = stall;
    assign flush_e     = stall;
    assign flush_d     = pc_sel_jr || pc_sel_j || pc_sel_br;
    assign stall_count = rst ? '0 : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rs_e  <= '0;
            rt_e  <= '0;
            wr_e  <= '0;
            rw_e  <= 1'b0;
            m2r_e <= 1'b0;
            wr_m  <= '0;
            rw_m  <= 1'b0;
            m2r_m <= 1'b0;
            wr_w  <= '0;
            rw_w  <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (stall) begin
                rs_e  <= '0;
                rt_e  <= '0;
                wr_e  <= '0;
                rw_e  <= 1'b0;
                m2r_e <= 1'b0;
            end else begin
                rs_e  <= rs_d;
                rt_e  <= rt_d;
                wr_e  <= write_reg_d;
                rw_e  <= reg_write_d;
                m2r_e <= mem_to_reg_d;
            end
            wr_m  <= wr_e;
            rw_m  <= rw_e;
            m2r_m <= m2r_e;
            wr_w  <= wr_m;
            rw_w  <= rw_m;
            if (stall && (cnt_q != '1))
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; expected values are hand-derived per step.
module tb_hazard_ctrl;
    localparam int REG_W = 5;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [REG_W-1:0] rs_d, rt_d, write_reg_d;
    logic             reg_write_d, mem_to_reg_d, branch_d, branch_taken_d, jump_d, jr_d;
    logic [1:0]       fwd_a_e, fwd_b_e;
    logic             fwd_a_d, fwd_b_d, pc_sel_jr, pc_sel_j, pc_sel_br;
    logic             stall_f, stall_d, flush_d, flush_e;
    logic [CNT_W-1:0] stall_count;

    int nvec = 0;
    int nerr = 0;

    hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs_d(rs_d), .rt_d(rt_d), .write_reg_d(write_reg_d),
        .reg_write_d(reg_write_d), .mem_to_reg_d(mem_to_reg_d),
        .branch_d(branch_d), .branch_taken_d(branch_taken_d),
        .jump_d(jump_d), .jr_d(jr_d),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
        .pc_sel_jr(pc_sel_jr), .pc_sel_j(pc_sel_j), .pc_sel_br(pc_sel_br),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input int rs, input int rt, input int wr, input int rw,
                          input int m2r, input int br, input int bt, input int j,
                          input int jr);
        rs_d           = rs[REG_W-1:0];
        rt_d           = rt[REG_W-1:0];
        write_reg_d    = wr[REG_W-1:0];
        reg_write_d    = rw[0];
        mem_to_reg_d   = m2r[0];
        branch_d       = br[0];
        branch_taken_d = bt[0];
        jump_d         = j[0];
        jr_d           = jr[0];
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        // reset with a JR in ID: everything must stay low
        rst = 1'b1;
        set_id(5, 6, 7, 1, 1, 0, 0, 0, 1);
        tick();
        tick();
        chk("rst_pc_sel_jr", pc_sel_jr, 0);
        chk("rst_flush_d", flush_d, 0);
        chk("rst_stall_f", stall_f, 0);
        chk("rst_count", stall_count, 0);
        rst = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // add $3,$1,$2 ; add $4,$3,$1 ; sub $5,$3,$0
        set_id(1, 2, 3, 1, 0, 0, 0, 0, 0);
        chk("fwdA_stall0", stall_f, 0);
        tick();
        set_id(3, 1, 4, 1, 0, 0, 0, 0, 0);
        chk("fwdA_alu_nostall", stall_d, 0);
        chk("fwdA_fad_empty", fwd_a_d, 0);
        tick();
        set_id(3, 0, 5, 1, 0, 0, 0, 0, 0);
        chk("fwdA_mem_a", fwd_a_e, 2);
        chk("fwdA_mem_b", fwd_b_e, 0);
        chk("fwdA_id_a", fwd_a_d, 1);
        chk("fwdA_id_b", fwd_b_d, 0);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("fwdA_wb_a", fwd_a_e, 1);
        chk("fwdA_wb_b", fwd_b_e, 0);

        // lw $2 ; add $6,$2,$2 -> one bubble
        do_reset();
        set_id(1, 0, 2, 1, 1, 0, 0, 0, 0);
        tick();
        set_id(2, 2, 6, 1, 0, 0, 0, 0, 0);
        chk("lu_stall_f", stall_f, 1);
        chk("lu_stall_d", stall_d, 1);
        chk("lu_flush_e", flush_e, 1);
        chk("lu_count0", stall_count, 0);
        tick();
        chk("lu_stall_clear", stall_f, 0);
        chk("lu_count1", stall_count, 1);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("lu_fwd_a_wb", fwd_a_e, 1);
        chk("lu_fwd_b_wb", fwd_b_e, 1);
        chk("lu_count_hold", stall_count, 1);

        // lw $7 ; beq $7,$0 taken -> two stall cycles then redirect
        do_reset();
        set_id(0, 0, 7, 1, 1, 0, 0, 0, 0);
        tick();
        set_id(7, 0, 0, 0, 0, 1, 1, 0, 0);
        chk("br_stall1", stall_f, 1);
        chk("br_nosel1", pc_sel_br, 0);
        chk("br_noflush1", flush_d, 0);
        tick();
        chk("br_stall2", stall_f, 1);
        chk("br_nosel2", pc_sel_br, 0);
        tick();
        chk("br_stall_done", stall_f, 0);
        chk("br_sel", pc_sel_br, 1);
        chk("br_flush_d", flush_d, 1);
        chk("br_count2", stall_count, 2);

        // jr + jump together: JR wins; then jump alone; untaken branch
        do_reset();
        set_id(5, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("pri_jr", pc_sel_jr, 1);
        chk("pri_j", pc_sel_j, 0);
        chk("pri_flush", flush_d, 1);
        set_id(0, 0, 0, 0, 0, 1, 1, 1, 0);
        chk("pri_j_only", pc_sel_j, 1);
        chk("pri_br_masked", pc_sel_br, 0);
        set_id(1, 2, 0, 0, 0, 1, 0, 0, 0);
        chk("br_untaken_sel", pc_sel_br, 0);
        chk("br_untaken_flush", flush_d, 0);

        // JR depending on ALU result in EX stalls
        do_reset();
        set_id(1, 2, 9, 1, 0, 0, 0, 0, 0);
        tick();
        set_id(9, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("jr_stall", stall_f, 1);
        chk("jr_nosel", pc_sel_jr, 0);
        tick();
        chk("jr_resolved", pc_sel_jr, 1);
        chk("jr_fad", fwd_a_d, 1);

        // writes to $0 never forward or stall
        do_reset();
        set_id(0, 0, 0, 1, 1, 0, 0, 0, 0);
        tick();
        set_id(0, 0, 9, 1, 0, 1, 1, 0, 0);
        chk("r0_nostall", stall_f, 0);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("r0_fwd_mem", fwd_a_e, 0);
        chk("r0_fad", fwd_a_d, 0);
        tick();
        chk("r0_fwd_wb", fwd_a_e, 0);

        // reset asserted mid-stall
        do_reset();
        set_id(1, 0, 2, 1, 1, 0, 0, 0, 0);
        tick();
        set_id(2, 2, 6, 1, 0, 0, 0, 0, 0);
        chk("mrst_pre_stall", stall_f, 1);
        rst = 1'b1;
        #1;
        chk("mrst_gate_stall", flush_e, 0);
        tick();
        chk("mrst_stall", stall_d, 0);
        chk("mrst_count", stall_count, 0);
        rst = 1'b0;
        #1;
        chk("mrst_dropped", stall_f, 0);

        // 19 load-use stalls with a 4-bit counter: saturate at 15
        do_reset();
        for (int k = 1; k <= 19; k++) begin
            set_id(1, 0, 2, 1, 1, 0, 0, 0, 0);
            tick();
            set_id(2, 2, 6, 1, 0, 0, 0, 0, 0);
            tick();
            tick();
            chk($sformatf("sat_count_%0d", k), stall_count, (k > 15) ? 15 : k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
